// File: rtl/bgpu_mem_tester_pkg.sv
// Shared types and the combinational pattern generator for the memory tester.
package bgpu_mem_tester_pkg;

  // Widest address/data/count the pattern helper handles.
  localparam int unsigned MaxWidth = 64;

  typedef logic [MaxWidth-1:0] word_t;

  typedef enum logic [1:0] {
    PatMul   = 2'd0,
    PatAddr  = 2'd1,
    PatWalk1 = 2'd2,
    PatConst = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrReq = 3'd1,
    StWrRsp = 3'd2,
    StRdReq = 3'd3,
    StRdRsp = 3'd4,
    StFin   = 3'd5
  } state_e;

  // Pattern word for index idx at address addr. Callers zero-extend their
  // operands into word_t and keep the low data_width bits of the result, so
  // the MUL product is correct modulo 2^data_width. data_width is a power of two.
  function automatic word_t pattern_data(input word_t idx, input word_t addr,
                                         input word_t seed, input pattern_e pat,
                                         input int unsigned data_width);
    word_t r;
    case (pat)
      PatMul:   r = idx * seed;
      PatAddr:  r = addr;
      PatWalk1: r = word_t'(1) << (idx & word_t'(data_width - 1));
      PatConst: r = seed;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bgpu_mem_tester.sv
// OBI manager that writes a pattern over a word range, optionally reads it
// back and compares, and reports error count and first failing location.
module bgpu_mem_tester
  import bgpu_mem_tester_pkg::*;
#(
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned CountWidth    = 16,
  parameter int unsigned ProgressWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [AddressWidth-1:0]  base_addr_i,
  input  logic [CountWidth-1:0]    num_words_i,
  input  logic [1:0]               pattern_i,
  input  logic [DataWidth-1:0]     seed_i,
  input  logic                     check_i,
  output logic                     obi_req_o,
  input  logic                     obi_gnt_i,
  output logic [AddressWidth-1:0]  obi_addr_o,
  output logic                     obi_we_o,
  output logic [DataWidth/8-1:0]   obi_be_o,
  output logic [DataWidth-1:0]     obi_wdata_o,
  input  logic                     obi_rvalid_i,
  input  logic [DataWidth-1:0]     obi_rdata_i,
  input  logic                     obi_err_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic                     error_o,
  output logic [CountWidth-1:0]    err_count_o,
  output logic [AddressWidth-1:0]  first_err_addr_o,
  output logic [DataWidth-1:0]     first_err_data_o,
  output logic [ProgressWidth-1:0] words_done_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam logic [AddressWidth-1:0] Step      = AddressWidth'(BeWidth);
  localparam logic [AddressWidth-1:0] AlignMask = ~AddressWidth'(BeWidth - 1);

  state_e                    state_q;
  pattern_e                  pat_q;
  logic [DataWidth-1:0]      seed_q;
  logic                      check_q;
  logic [CountWidth-1:0]     num_q, idx_q;
  logic [AddressWidth-1:0]   base_q, addr_q;
  logic                      req_q, we_q;
  logic [DataWidth-1:0]      wdata_q;
  logic                      busy_q, done_q, aborted_q, error_q;
  logic [CountWidth-1:0]     err_cnt_q;
  logic [AddressWidth-1:0]   fa_q;
  logic [DataWidth-1:0]      fd_q;
  logic [ProgressWidth-1:0]  wdone_q;

  // Next-word selection: first word of a phase or the following word.
  logic [CountWidth-1:0]     nidx_d;
  logic [AddressWidth-1:0]   naddr_d, base_in_d;
  pattern_e                  npat_d;
  logic [DataWidth-1:0]      nseed_d, ndata_d;
  word_t                     idx_ext, addr_ext, seed_ext, pat_full;
  logic                      last_d, rsp_err_d, stop_d;
  logic                      unused_pat;

  // Pick index/address/config for the word about to be requested and derive its pattern.
  always_comb begin
    base_in_d = base_addr_i & AlignMask;
    last_d    = (idx_q + CountWidth'(1)) == num_q;
    nidx_d    = idx_q + CountWidth'(1);
    naddr_d   = addr_q + Step;
    npat_d    = pat_q;
    nseed_d   = seed_q;
    if (state_q == StIdle) begin
      nidx_d  = '0;
      naddr_d = base_in_d;
      npat_d  = pattern_e'(pattern_i);
      nseed_d = seed_i;
    end else if (state_q == StWrRsp && last_d) begin
      nidx_d  = '0;
      naddr_d = base_q;
    end
    idx_ext  = '0;
    addr_ext = '0;
    seed_ext = '0;
    idx_ext[CountWidth-1:0]    = nidx_d;
    addr_ext[AddressWidth-1:0] = naddr_d;
    seed_ext[DataWidth-1:0]    = nseed_d;
    pat_full   = pattern_data(idx_ext, addr_ext, seed_ext, npat_d, DataWidth);
    ndata_d    = pat_full[DataWidth-1:0];
    unused_pat = ^pat_full;
    // wdata_q still holds pattern(i) during reads, so it doubles as the expected value.
    rsp_err_d  = obi_err_i | ((state_q == StRdRsp) && (obi_rdata_i != wdata_q));
    stop_d     = aborted_q | abort_i;
  end

  // Run controller: request issue, response accounting, error capture, abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pat_q     <= PatMul;
      seed_q    <= '0;
      check_q   <= 1'b0;
      num_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      fa_q      <= '0;
      fd_q      <= '0;
      wdone_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            pat_q     <= npat_d;
            seed_q    <= seed_i;
            check_q   <= check_i;
            num_q     <= num_words_i;
            base_q    <= base_in_d;
            busy_q    <= 1'b1;
            aborted_q <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            fa_q      <= '0;
            fd_q      <= '0;
            wdone_q   <= '0;
            if (num_words_i == '0) begin
              state_q <= StFin;
            end else begin
              idx_q   <= nidx_d;
              addr_q  <= naddr_d;
              wdata_q <= ndata_d;
              we_q    <= 1'b1;
              req_q   <= 1'b1;
              state_q <= StWrReq;
            end
          end
        end
        StWrReq, StRdReq: begin
          // A grant in the abort cycle means the bus took the beat: finish it first.
          if (obi_gnt_i) begin
            req_q <= 1'b0;
            if (abort_i) aborted_q <= 1'b1;
            state_q <= (state_q == StWrReq) ? StWrRsp : StRdRsp;
          end else if (abort_i) begin
            req_q     <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= StFin;
          end
        end
        StWrRsp, StRdRsp: begin
          if (abort_i) aborted_q <= 1'b1;
          if (obi_rvalid_i) begin
            wdone_q <= wdone_q + ProgressWidth'(1);
            if (rsp_err_d) begin
              error_q <= 1'b1;
              if (err_cnt_q == '0) begin
                fa_q <= addr_q;
                fd_q <= (state_q == StRdRsp) ? obi_rdata_i : '0;
              end
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CountWidth'(1);
            end
            if (stop_d) begin
              state_q <= StFin;
            end else if (last_d) begin
              if (state_q == StWrRsp && check_q) begin
                wdone_q <= '0;
                idx_q   <= nidx_d;
                addr_q  <= naddr_d;
                wdata_q <= ndata_d;
                we_q    <= 1'b0;
                req_q   <= 1'b1;
                state_q <= StRdReq;
              end else begin
                state_q <= StFin;
              end
            end else begin
              idx_q   <= nidx_d;
              addr_q  <= naddr_d;
              wdata_q <= ndata_d;
              req_q   <= 1'b1;
              state_q <= (state_q == StWrRsp) ? StWrReq : StRdReq;
            end
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign obi_req_o        = req_q;
  assign obi_addr_o       = addr_q;
  assign obi_we_o         = we_q;
  assign obi_be_o         = '1;
  assign obi_wdata_o      = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;
  assign error_o          = error_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = fa_q;
  assign first_err_data_o = fd_q;
  assign words_done_o     = wdone_q;

endmodule

// File: tb/tb_bgpu_mem_tester.sv
// Bench for bgpu_mem_tester: OBI memory responder with random latencies,
// fault injection, and a run-level reference model.
module tb_bgpu_mem_tester;

  logic        clk = 1'b0;
  logic        rst, start, abort_rsp, check;
  logic [31:0] base, seed;
  logic [15:0] nwords;
  logic [1:0]  pat_s;
  logic        req, gnt, we, rvalid, rerr;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        busy, done, aborted, error;
  logic [15:0] err_count, words_done;
  logic [31:0] fa, fd;

  always #5 clk = ~clk;

  bgpu_mem_tester dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort_rsp),
    .base_addr_i(base), .num_words_i(nwords), .pattern_i(pat_s), .seed_i(seed),
    .check_i(check), .obi_req_o(req), .obi_gnt_i(gnt), .obi_addr_o(addr),
    .obi_we_o(we), .obi_be_o(be), .obi_wdata_o(wdata), .obi_rvalid_i(rvalid),
    .obi_rdata_i(rdata), .obi_err_i(rerr), .busy_o(busy), .done_o(done),
    .aborted_o(aborted), .error_o(error), .err_count_o(err_count),
    .first_err_addr_o(fa), .first_err_data_o(fd), .words_done_o(words_done)
  );

  int checks = 0, errors = 0;

  // Memory model and fault-injection controls.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] r_base = 0;
  int          wr_err_idx = -1, c1_idx = -1, c2_idx = -1, abort_rd_idx = -1;
  logic [31:0] c1_val = 0, c2_val = 0;
  int          grants = 0, stab_viol = 0, done_cnt = 0, req_cycles = 0;
  logic [31:0] glog [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a - r_base) >> 2);
  endfunction

  function automatic logic [31:0] exp_pat(input int p, input logic [31:0] i,
                                          input logic [31:0] b, input logic [31:0] s);
    case (p)
      0:       return i * s;
      1:       return b + 32'd4 * i;
      2:       return 32'h1 << (i % 32);
      default: return s;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (req) req_cycles++;
  end

  // OBI subordinate: grant after 0..3 cycles, respond 1..3 cycles after grant.
  initial begin : responder
    bit          armed, pend, p_we;
    int          gwait, rwait;
    logic [31:0] p_addr, a_addr, a_wdata, d;
    bit          a_we;
    armed = 0; pend = 0; p_we = 0; gwait = 0; rwait = 0;
    p_addr = 0; a_addr = 0; a_wdata = 0; a_we = 0; d = 0;
    gnt = 0; rvalid = 0; rdata = 0; rerr = 0; abort_rsp = 0;
    forever begin
      @(posedge clk); #1;
      gnt = 0; rvalid = 0; rerr = 0;
      if (abort_rd_idx < 0) abort_rsp = 0;
      if (rst) begin
        armed = 0; pend = 0;
      end else if (pend) begin
        if (abort_rd_idx >= 0 && !p_we && widx(p_addr) == abort_rd_idx) abort_rsp = 1;
        rwait--;
        if (rwait == 0) begin
          pend = 0; rvalid = 1;
          if (p_we) begin
            rerr  = (widx(p_addr) == wr_err_idx);
            rdata = $urandom;
          end else begin
            d = mem.exists(p_addr) ? mem[p_addr] : 32'h0;
            if (widx(p_addr) == c1_idx) d = c1_val;
            if (widx(p_addr) == c2_idx) d = c2_val;
            rdata = d;
          end
        end
      end else if (req) begin
        if (!armed) begin
          armed = 1; gwait = $urandom_range(0, 3);
          a_addr = addr; a_we = we; a_wdata = wdata;
        end else if (addr !== a_addr || we !== a_we || wdata !== a_wdata) begin
          stab_viol++;
        end
        if (gwait == 0) begin
          gnt = 1; armed = 0; pend = 1; rwait = $urandom_range(1, 3);
          p_addr = addr; p_we = we; grants++; glog.push_back(addr);
          // Errored writes still land in the model memory; read-back then matches.
          if (we) mem[addr] = wdata;
        end else begin
          gwait--;
        end
      end else begin
        armed = 0;
      end
    end
  end

  task automatic start_run(input logic [31:0] b, input int n, input int p,
                           input logic [31:0] s, input bit c);
    @(posedge clk); #1;
    r_base = b; grants = 0; glog.delete();
    base = b; nwords = 16'(n); pat_s = 2'(p); seed = s; check = c; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  // Run one complete test and compare status against the run-level model.
  task automatic run_and_check(input string tag, input logic [31:0] b, input int n,
                               input int p, input logic [31:0] s, input bit c);
    int          e_cnt, d0, j;
    logic [31:0] e_fa, e_fd, last_a;
    d0 = done_cnt;
    start_run(b, n, p, s, c);
    wait_done(tag);
    e_cnt = 0; e_fa = 0; e_fd = 0;
    if (wr_err_idx >= 0 && wr_err_idx < n) begin
      e_cnt = 1; e_fa = b + 32'(4 * wr_err_idx); e_fd = 0;
    end
    if (c) begin
      for (int k = 0; k < 2; k++) begin
        j = (k == 0) ? ((c1_idx >= 0 && (c2_idx < 0 || c1_idx < c2_idx)) ? c1_idx : c2_idx)
                     : ((c1_idx >= 0 && (c2_idx < 0 || c1_idx < c2_idx)) ? c2_idx : c1_idx);
        if (j >= 0 && j < n) begin
          if (e_cnt == 0) begin
            e_fa = b + 32'(4 * j);
            e_fd = (j == c1_idx) ? c1_val : c2_val;
          end
          e_cnt++;
        end
      end
    end
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_errcnt"}, err_count, e_cnt);
    chk({tag, "_error"}, error, e_cnt != 0);
    chk({tag, "_fa"}, fa, e_fa);
    chk({tag, "_fd"}, fd, e_fd);
    chk({tag, "_wdone"}, words_done, n);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_grants"}, grants, c ? 2 * n : n);
    last_a = b + 32'(4 * (n - 1));
    chk({tag, "_memlast"}, mem.exists(last_a) ? mem[last_a] : 32'hx, exp_pat(p, 32'(n - 1), b, s));
    @(negedge clk); @(negedge clk);
    chk({tag, "_donepulses"}, done_cnt - d0, 1);
    chk({tag, "_errhold"}, err_count, e_cnt);
  endtask

  initial begin : main
    logic [31:0] s, b;
    int          n, p, d0, rq0;
    bit          c;
    rst = 1; start = 0; check = 0; base = 0; seed = 0; nwords = 0; pat_s = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req, 0);   chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_abort", aborted, 0); chk("rst_err", error, 0); chk("rst_cnt", err_count, 0);
    chk("rst_fa", fa, 0); chk("rst_fd", fd, 0); chk("rst_wd", words_done, 0);
    chk("rst_addr", addr, 0); chk("rst_be", be, 4'hF);
    @(posedge clk); #1 rst = 0;

    // MUL pattern with read-back, clean memory.
    s = 32'h12345678;
    run_and_check("mul", 32'h0, 10, 0, s, 1);
    chk("mul_mem24", mem[32'h24], 32'd9 * s);

    // Same run with two corrupted reads.
    c1_idx = 3; c1_val = 32'hDEADBEEF; c2_idx = 7; c2_val = ~(32'd7 * s);
    run_and_check("corrupt", 32'h0, 10, 0, s, 1);
    c1_idx = -1; c2_idx = -1;

    // Address wrap-around with ADDR pattern.
    run_and_check("wrap", 32'hFFFFFFF8, 4, 1, 32'h0, 1);
    chk("wrap_a0", glog[0], 32'hFFFFFFF8); chk("wrap_a1", glog[1], 32'hFFFFFFFC);
    chk("wrap_a2", glog[2], 32'h0);        chk("wrap_a3", glog[3], 32'h4);

    // Zero words: straight to FIN, no bus traffic.
    rq0 = req_cycles; d0 = done_cnt;
    start_run(32'h100, 0, 0, 32'h1, 1);
    @(negedge clk); chk("zero_busy1", busy, 1); chk("zero_done1", done, 0);
    @(negedge clk); chk("zero_busy2", busy, 0); chk("zero_done2", done, 1);
    @(negedge clk); chk("zero_done3", done, 0);
    chk("zero_req", req_cycles - rq0, 0); chk("zero_pulses", done_cnt - d0, 1);

    // Abort while waiting for read response of word 20.
    abort_rd_idx = 20;
    start_run(32'h1000, 100, 2, 32'h0, 1);
    wait_done("abort");
    chk("abort_flag", aborted, 1); chk("abort_wd", words_done, 21);
    chk("abort_grants", grants, 121); chk("abort_err", err_count, 0);
    repeat (5) @(negedge clk);
    chk("abort_noreq", req, 0); chk("abort_grants2", grants, 121);
    abort_rd_idx = -1;
    repeat (2) @(negedge clk);

    // Write bus error, no read-back.
    wr_err_idx = 2;
    run_and_check("wrerr", 32'h0, 5, 0, 32'h3, 0);
    wr_err_idx = -1;

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      b = $urandom; b = b & 32'hFFFFFFFC;
      n = $urandom_range(1, 24); p = $urandom_range(0, 3); s = $urandom;
      c = 1'($urandom_range(0, 1));
      wr_err_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      if (c && $urandom_range(0, 1) == 1) begin
        c1_idx = $urandom_range(0, n - 1);
        c1_val = exp_pat(p, 32'(c1_idx), b, s) ^ ($urandom | 32'h1);
      end else c1_idx = -1;
      run_and_check($sformatf("rand%0d", k), b, n, p, s, c);
    end
    wr_err_idx = -1; c1_idx = -1;

    // Reset mid-run clears everything on the next edge.
    start_run(32'h2000, 50, 0, 32'h5, 0);
    repeat (15) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); @(negedge clk);
    chk("mrst_req", req, 0); chk("mrst_busy", busy, 0); chk("mrst_wd", words_done, 0);
    chk("mrst_addr", addr, 0); chk("mrst_wdata", wdata, 0);
    @(posedge clk); #1 rst = 0;
    repeat (8) @(negedge clk);
    chk("mrst_idle_req", req, 0); chk("mrst_idle_busy", busy, 0);
    chk("stability", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
